// File: rtl/iir_out_decim_if.sv
// Sample stream bundle for iir_out_decim: filter samples in, decimated samples out.
// The slave modport is the block itself; the master modport is the producer/consumer side.
interface iir_out_decim_if #(
  parameter int BITWIDTH = 32,
  parameter int OUT_W    = 16
);
  logic signed [BITWIDTH-1:0] x;
  logic                       x_valid;
  logic signed [OUT_W-1:0]    m_data;
  logic                       m_valid;
  logic                       m_ready;

  modport master (output x, x_valid, m_ready, input m_data, m_valid);
  modport slave  (input x, x_valid, m_ready, output m_data, m_valid);
endinterface

// File: rtl/iir_out_decim.sv
// Decimating output stage: keeps every DECIM-th sample, rounds half up to OUT_FAC fraction
// bits, saturates to OUT_W, and buffers results in a small FIFO with sticky sat/ovf flags.
module iir_out_decim #(
  parameter int BITWIDTH = 32,
  parameter int FAC      = 20,
  parameter int OUT_W    = 16,
  parameter int OUT_FAC  = 8,
  parameter int DECIM    = 4,
  parameter int DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  iir_out_decim_if.slave       bus,
  output logic                 sat,
  output logic                 ovf,
  input  logic                 flag_clr
);

  localparam int SH    = FAC - OUT_FAC;
  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [BITWIDTH:0] HALF = {{BITWIDTH{1'b0}}, 1'b1} << (SH - 1);

  // Round half up at one extra bit so x + HALF can never wrap.
  function automatic logic signed [BITWIDTH:0] round_hu(input logic signed [BITWIDTH-1:0] v);
    logic signed [BITWIDTH:0] ext;
    ext = {v[BITWIDTH-1], v};
    ext = ext + $signed(HALF);
    return ext >>> SH;
  endfunction

  // Returns {saturated, value}; the value fits when all bits above the output sign agree.
  function automatic logic [OUT_W:0] sat_out(input logic signed [BITWIDTH:0] r);
    logic [BITWIDTH-OUT_W+1:0] top;
    top = r[BITWIDTH:OUT_W-1];
    if (top == '0 || top == '1)
      return {1'b0, r[OUT_W-1:0]};
    else if (r[BITWIDTH])
      return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  logic [CNT_W-1:0]         cnt;
  logic                     keep;
  logic signed [BITWIDTH:0] r_p0;
  logic [OUT_W:0]           sv_p0;

  logic                     s_valid;
  logic signed [OUT_W-1:0]  s_data;
  logic                     s_sat;

  logic signed [OUT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W:0]           count;
  logic                     full;
  logic                     pop;
  logic                     push_ok;
  logic                     drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (bus.x_valid)
      cnt <= (cnt == CNT_W'(DECIM - 1)) ? '0 : cnt + CNT_W'(1);
  end

  assign keep  = bus.x_valid && (cnt == '0);
  assign r_p0  = round_hu(bus.x);
  assign sv_p0 = sat_out(r_p0);

  // ---- stage p0 -> stage register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_valid <= 1'b0;
      s_data  <= '0;
      s_sat   <= 1'b0;
    end else begin
      s_valid <= keep;
      if (keep) begin
        s_data <= sv_p0[OUT_W-1:0];
        s_sat  <= sv_p0[OUT_W];
      end
    end
  end

  // ---- stage register -> FIFO
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign pop     = (count != '0) && bus.m_ready;
  assign push_ok = s_valid && (!full || pop);
  assign drop    = s_valid && !push_ok;

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Head is forced to zero while empty so reset leaves m_data clean without resetting storage.
  assign bus.m_valid = (count != '0);
  assign bus.m_data  = bus.m_valid ? mem[rd_ptr] : '0;

  // Sticky flags: a set event in the same cycle beats flag_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (s_valid && s_sat)
        sat <= 1'b1;
      else if (flag_clr)
        sat <= 1'b0;
      if (drop)
        ovf <= 1'b1;
      else if (flag_clr)
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iir_out_decim.sv
// Directed bench for iir_out_decim at default parameters (SH = 12, DECIM = 4, DEPTH = 4).
module tb_iir_out_decim;

  logic clk = 1'b0;
  logic rst;
  logic sat, ovf, flag_clr;
  logic [15:0] md;
  int n_vec = 0;
  int n_err = 0;
  logic mon_en = 1'b0;
  logic [15:0] mon_q[$];

  iir_out_decim_if #(.BITWIDTH(32), .OUT_W(16)) bus ();

  iir_out_decim dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .sat      (sat),
    .ovf      (ovf),
    .flag_clr (flag_clr)
  );

  always #5 clk = ~clk;
  assign md = bus.m_data;

  always @(negedge clk)
    if (mon_en && bus.m_valid && bus.m_ready) mon_q.push_back(md);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_x(input logic [31:0] v);
    bus.x       = v;
    bus.x_valid = 1'b1;
    step();
    bus.x_valid = 1'b0;
    bus.x       = '0;
  endtask

  // One kept sample followed by three discarded fillers, leaving the counter at 0.
  task automatic kept(input logic [31:0] v);
    push_x(v);
    repeat (3) push_x(32'h0);
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] exp);
    chk({tag, "_vld"}, {31'h0, bus.m_valid}, 32'h1);
    chk(tag, {16'h0, md}, {16'h0, exp});
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
  endtask

  task automatic clr_flags();
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d0, d1;
    rst = 1'b0; flag_clr = 1'b0;
    bus.x = '0; bus.x_valid = 1'b0; bus.m_ready = 1'b0;
    repeat (2) step();
    chk("rst_mvalid", {31'h0, bus.m_valid}, 32'h0);
    chk("rst_mdata",  {16'h0, md},          32'h0);
    chk("rst_sat",    {31'h0, sat},         32'h0);
    chk("rst_ovf",    {31'h0, ovf},         32'h0);
    rst = 1'b1;

    // Rounding
    kept(32'h0000_1800);
    kept(32'h0000_07FF);
    kept(32'hFFFF_FFFF);
    chk("rnd_sat", {31'h0, sat}, 32'h0);
    pop_chk("rnd_1800", 16'h0002);
    pop_chk("rnd_07ff", 16'h0000);
    pop_chk("rnd_m1",   16'h0000);
    chk("rnd_empty", {31'h0, bus.m_valid}, 32'h0);

    // Saturation
    kept(32'h7FFF_FFFF);
    chk("sat_pos_flag", {31'h0, sat}, 32'h1);
    pop_chk("sat_pos", 16'h7FFF);
    clr_flags();
    chk("sat_clr", {31'h0, sat}, 32'h0);
    kept(32'h8000_0000);
    pop_chk("sat_neg", 16'h8000);
    chk("sat_neg_flag", {31'h0, sat}, 32'h1);
    clr_flags();
    chk("sat_clr2", {31'h0, sat}, 32'h0);

    // Latency: sample driven, edge 1 captures into stage, edge 2 pushes
    bus.x = 32'h0000_1800; bus.x_valid = 1'b1;
    step();
    bus.x_valid = 1'b0; bus.x = '0;
    chk("lat_edge1", {31'h0, bus.m_valid}, 32'h0);
    step();
    chk("lat_edge2", {31'h0, bus.m_valid}, 32'h1);
    repeat (2) push_x(32'h0);
    push_x(32'h0);
    pop_chk("lat_data", 16'h0002);

    // Decimation with a two-cycle gap in x_valid
    mon_q.delete();
    mon_en = 1'b1;
    bus.m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      push_x(32'(k) * 32'h1000);
      if (k == 2) repeat (2) step();
    end
    repeat (3) step();
    bus.m_ready = 1'b0;
    mon_en = 1'b0;
    chk("dec_count", 32'(mon_q.size()), 32'd2);
    d0 = (mon_q.size() > 0) ? mon_q[0] : 16'hDEAD;
    d1 = (mon_q.size() > 1) ? mon_q[1] : 16'hDEAD;
    chk("dec_out0", {16'h0, d0}, 32'h0000);
    chk("dec_out1", {16'h0, d1}, 32'h0004);

    // Full FIFO: fifth kept sample dropped
    for (int k = 1; k <= 5; k++) kept(32'(k) * 32'h1000);
    chk("full_mvalid", {31'h0, bus.m_valid}, 32'h1);
    chk("full_head",   {16'h0, md},          32'h0001);
    chk("full_ovf",    {31'h0, ovf},         32'h1);
    clr_flags();
    chk("ovf_clr", {31'h0, ovf}, 32'h0);
    // Push and pop on the same edge while full
    bus.x = 32'h0000_6000; bus.x_valid = 1'b1;
    step();
    bus.x_valid = 1'b0; bus.x = '0;
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
    chk("pp_ovf", {31'h0, ovf}, 32'h0);
    repeat (3) push_x(32'h0);
    pop_chk("pp_0", 16'h0002);
    pop_chk("pp_1", 16'h0003);
    pop_chk("pp_2", 16'h0004);
    pop_chk("pp_3", 16'h0006);
    chk("pp_empty", {31'h0, bus.m_valid}, 32'h0);

    // Asynchronous reset with samples buffered and one in the stage register
    kept(32'h0000_1000);
    kept(32'h0000_2000);
    kept(32'h7FFF_FFFF);
    chk("mr_sat_pre", {31'h0, sat}, 32'h1);
    push_x(32'h0000_9000);
    #2 rst = 1'b0;
    #1;
    chk("mr_mvalid", {31'h0, bus.m_valid}, 32'h0);
    chk("mr_mdata",  {16'h0, md},          32'h0);
    chk("mr_sat",    {31'h0, sat},         32'h0);
    chk("mr_ovf",    {31'h0, ovf},         32'h0);
    step();
    rst = 1'b1;
    push_x(32'h0000_A000);
    step();
    pop_chk("mr_first", 16'h000A);
    repeat (3) step();
    chk("mr_empty", {31'h0, bus.m_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
